ib_issue_unit: RTL and testbench
================================

# ib_issue_unit

Per-warp instruction buffer and issue arbiter on the sending side of the instruction-buffer-to-operand-collector interface. It holds decoded instructions for 8 hardware warps in 2-entry FIFOs and selects one ready warp per cycle round-robin. It drives the `*_IB_OC` instruction bundle and respects `Full_OC_IB` backpressure. It also reports the issuing warp and warp exits to the register allocation unit, and blocks a warp after a branch until EX resolves it.

## Interface
- No parameters; 8 warps, 2 entries per warp, fixed.
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- Valid_ID_IB  in  1  decoded instruction write strobe
- HWWarp_ID_IB  in  3  target warp of the write
- Instr/Src1/Src1_Valid/Src2/Src2_Valid/Imme/Imme_Valid/ALUop/RegWrite/MemWrite/MemRead/Shared_Globalbar/BEQ/BLT/ScbID/ActiveMask `_ID_IB`  in  32/5/1/5/1/16/1/4/1/1/1/1/1/1/2/8  decoded fields, captured with Valid_ID_IB
- Exit_ID_IB  in  1  instruction is warp exit
- Full_IB_ID  out  8  per-warp FIFO full (count==2)
- Full_OC_IB  in  1  operand collector cannot take a new instruction
- AllocStall_RAU_IB  in  1  RAU stall; blocks all issue
- BrResolve_EX_IB  in  1  branch resolved strobe
- BrWarp_EX_IB  in  3  warp of resolved branch
- BrTaken_EX_IB  in  1  resolved branch was taken
- Valid_IB_OC  out  1  issue strobe, one cycle per instruction
- Same 16 fields `_IB_OC`  out  same widths  issued instruction bundle
- HWWarp_IB_RAU  out  3  warp of the issued instruction
- ExitEN_IB_RAU  out  1  pulse: issued instruction was an exit
- ExitWarpID_IB_RAU  out  3  warp that exited

## Operation
- Per-warp state: 2-entry FIFO (rd ptr, wr ptr, 2-bit count), `br_pend` bit. Global: 3-bit RR pointer `last`.
- Write: if Valid_ID_IB and count[w]<2 and no flush of w this cycle, push entry. A write to a full warp is dropped; the ID stage must gate on Full_IB_ID.
- Warp w is ready when count[w]>0 and br_pend[w]==0.
- Issue allowed when Full_OC_IB==0 and AllocStall_RAU_IB==0 and some warp is ready.
- Selection: first ready warp searching last+1, last+2, … mod 8. On issue: pop head, last←w.
- Issued head with BEQ or BLT: set br_pend[w].
- BrResolve_EX_IB: clear br_pend[BrWarp]. If BrTaken, also flush that warp's FIFO (count←0, ptrs←0).
- Issued head with Exit: ExitEN_IB_RAU=1, ExitWarpID_IB_RAU=w, flush warp w's remaining entries, clear br_pend[w].
- Simultaneous push and pop on the same warp: count unchanged, both take effect. A push is legal when count==2 only if that warp pops in the same cycle.
- Simultaneous push and flush on the same warp: flush wins, the push is dropped.
- Resolve and issue for the same warp in one cycle: the resolve is applied first. The warp is not ready until the next cycle; readiness uses registered br_pend.

## Timing
- All outputs registered. Selection in cycle N gives Valid_IB_OC=1 with the bundle in cycle N+1. HWWarp_IB_RAU and Exit outputs are valid in the same cycle N+1.
- Min latency write→issue: write in cycle N, entry visible N+1, Valid_IB_OC at N+2.
- Full_OC_IB is sampled in the selection cycle. The OC must accept a Valid_IB_OC that follows a cycle with Full_OC_IB=0.
- Throughput: one issue per cycle when warps are ready.
- Full_IB_ID is registered from count and reflects state after the previous edge.
- Reset (rst_n=0 at an edge, any time, including mid-stream): all FIFOs empty, br_pend=0, last=7 (warp 0 has first priority).
- Reset values of outputs: Valid_IB_OC=0, ExitEN_IB_RAU=0, Full_IB_ID=0, all bundle, warp-ID and exit-warp outputs 0.
- When no issue, Valid_IB_OC=0 and ExitEN_IB_RAU=0. Bundle outputs hold their last value.

## Test plan
- Reset, write one ALU instr to warp 3 at cycle 1 → Valid_IB_OC=1 at cycle 3 with matching fields, HWWarp_IB_RAU=3.
- Fill warps 0,2,5 with 2 instrs each, no stall → issue order 0,2,5,0,2,5 on consecutive cycles; Full_IB_ID bits clear as each drains.
- Full_OC_IB=1 for cycles 4–6 with warp 1 loaded → no Valid_IB_OC in cycles 5–7; issue resumes at cycle 8. Same behaviour with AllocStall_RAU_IB.
- Warp 4: BEQ then ADD → BEQ issues, ADD held. BrResolve with BrTaken=0 → ADD issues 2 cycles later. Repeat with BrTaken=1 → ADD flushed, never issued.
- Warp 6: EXIT followed by a queued instr and a same-cycle write → ExitEN_IB_RAU=1, ExitWarpID_IB_RAU=6, queued and new instrs dropped, count[6]=0.
- Assert rst_n=0 mid-stream with 4 warps loaded and br_pend set → next cycle all outputs 0, Full_IB_ID=0. After release, a write to warp 7 issues normally.

Source files
------------

// File: rtl/ib_issue_unit.sv
// Per-warp 2-entry instruction buffer with round-robin issue to the operand collector.
// Also tracks pending branches per warp and reports issue and exit events to the RAU.
module ib_issue_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Valid_ID_IB,
    input  logic [2:0]  HWWarp_ID_IB,
    input  logic [31:0] Instr_ID_IB,
    input  logic [4:0]  Src1_ID_IB,
    input  logic        Src1_Valid_ID_IB,
    input  logic [4:0]  Src2_ID_IB,
    input  logic        Src2_Valid_ID_IB,
    input  logic [15:0] Imme_ID_IB,
    input  logic        Imme_Valid_ID_IB,
    input  logic [3:0]  ALUop_ID_IB,
    input  logic        RegWrite_ID_IB,
    input  logic        MemWrite_ID_IB,
    input  logic        MemRead_ID_IB,
    input  logic        Shared_Globalbar_ID_IB,
    input  logic        BEQ_ID_IB,
    input  logic        BLT_ID_IB,
    input  logic [1:0]  ScbID_ID_IB,
    input  logic [7:0]  ActiveMask_ID_IB,
    input  logic        Exit_ID_IB,
    output logic [7:0]  Full_IB_ID,
    input  logic        Full_OC_IB,
    input  logic        AllocStall_RAU_IB,
    input  logic        BrResolve_EX_IB,
    input  logic [2:0]  BrWarp_EX_IB,
    input  logic        BrTaken_EX_IB,
    output logic        Valid_IB_OC,
    output logic [31:0] Instr_IB_OC,
    output logic [4:0]  Src1_IB_OC,
    output logic        Src1_Valid_IB_OC,
    output logic [4:0]  Src2_IB_OC,
    output logic        Src2_Valid_IB_OC,
    output logic [15:0] Imme_IB_OC,
    output logic        Imme_Valid_IB_OC,
    output logic [3:0]  ALUop_IB_OC,
    output logic        RegWrite_IB_OC,
    output logic        MemWrite_IB_OC,
    output logic        MemRead_IB_OC,
    output logic        Shared_Globalbar_IB_OC,
    output logic        BEQ_IB_OC,
    output logic        BLT_IB_OC,
    output logic [1:0]  ScbID_IB_OC,
    output logic [7:0]  ActiveMask_IB_OC,
    output logic [2:0]  HWWarp_IB_RAU,
    output logic        ExitEN_IB_RAU,
    output logic [2:0]  ExitWarpID_IB_RAU
);
    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  src1;
        logic        src1_valid;
        logic [4:0]  src2;
        logic        src2_valid;
        logic [15:0] imme;
        logic        imme_valid;
        logic [3:0]  aluop;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        shared_globalbar;
        logic        beq;
        logic        blt;
        logic [1:0]  scb_id;
        logic [7:0]  active_mask;
    } fields_t;

    typedef struct packed {
        fields_t f;
        logic    exit;
    } entry_t;

    entry_t          mem [8][2];
    logic [7:0][1:0] cnt, cnt_n;
    logic [7:0]      rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n, br_pend, br_pend_n;
    logic [7:0]      ready, flush, full_n;
    logic [2:0]      last, sel_warp;
    logic            sel_found, issue, push_ok;
    entry_t          wr_entry, head;
    fields_t         bundle_q;

    assign wr_entry = '{f: '{Instr_ID_IB, Src1_ID_IB, Src1_Valid_ID_IB, Src2_ID_IB,
                             Src2_Valid_ID_IB, Imme_ID_IB, Imme_Valid_ID_IB, ALUop_ID_IB,
                             RegWrite_ID_IB, MemWrite_ID_IB, MemRead_ID_IB,
                             Shared_Globalbar_ID_IB, BEQ_ID_IB, BLT_ID_IB, ScbID_ID_IB,
                             ActiveMask_ID_IB},
                        exit: Exit_ID_IB};

    // Readiness uses registered br_pend, so a same-cycle resolve only helps next cycle.
    always_comb begin
        for (int w = 0; w < 8; w++) begin
            ready[w] = (cnt[w] != 2'd0) && !br_pend[w];
        end
    end

    always_comb begin
        logic [2:0] idx;
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        idx       = '0;
        sel_found = 1'b0;
        sel_warp  = '0;
        for (int i = 1; i <= 8; i++) begin
            idx = last + 3'(i);
            if (!sel_found && ready[idx]) begin
                sel_found = 1'b1;
                sel_warp  = idx;
            end
        end
    end

    assign head  = mem[sel_warp][rd_ptr[sel_warp]];
    assign issue = sel_found && !Full_OC_IB && !AllocStall_RAU_IB;

    always_comb begin
        for (int w = 0; w < 8; w++) begin
            flush[w] = (BrResolve_EX_IB && BrTaken_EX_IB && BrWarp_EX_IB == 3'(w)) ||
                       (issue && head.exit && sel_warp == 3'(w));
        end
    end

    // A push into a full warp is only legal when that warp pops in the same cycle.
    assign push_ok = Valid_ID_IB && !flush[HWWarp_ID_IB] &&
                     (cnt[HWWarp_ID_IB] != 2'd2 || (issue && sel_warp == HWWarp_ID_IB));

    always_comb begin
        cnt_n     = cnt;
        rd_ptr_n  = rd_ptr;
        wr_ptr_n  = wr_ptr;
        br_pend_n = br_pend;
        if (BrResolve_EX_IB) br_pend_n[BrWarp_EX_IB] = 1'b0;
        if (issue) begin
            rd_ptr_n[sel_warp] = ~rd_ptr[sel_warp];
            cnt_n[sel_warp]    = cnt_n[sel_warp] - 2'd1;
            if (head.f.beq || head.f.blt) br_pend_n[sel_warp] = 1'b1;
            if (head.exit)                br_pend_n[sel_warp] = 1'b0;
        end
        if (push_ok) begin
            wr_ptr_n[HWWarp_ID_IB] = ~wr_ptr[HWWarp_ID_IB];
            cnt_n[HWWarp_ID_IB]    = cnt_n[HWWarp_ID_IB] + 2'd1;
        end
        for (int w = 0; w < 8; w++) begin
            if (flush[w]) begin
                cnt_n[w]    = 2'd0;
                rd_ptr_n[w] = 1'b0;
                wr_ptr_n[w] = 1'b0;
            end
            full_n[w] = (cnt_n[w] == 2'd2);
        end
    end

    // NOTE: storage is not reset; the counts gate every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push_ok) mem[HWWarp_ID_IB][wr_ptr[HWWarp_ID_IB]] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt               <= '0;
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            br_pend           <= '0;
            last              <= 3'd7;
            Full_IB_ID        <= '0;
            Valid_IB_OC       <= 1'b0;
            ExitEN_IB_RAU     <= 1'b0;
            bundle_q          <= '0;
            HWWarp_IB_RAU     <= '0;
            ExitWarpID_IB_RAU <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt           <= cnt_n;
            rd_ptr        <= rd_ptr_n;
            wr_ptr        <= wr_ptr_n;
            br_pend       <= br_pend_n;
            Full_IB_ID    <= full_n;
            Valid_IB_OC   <= issue;
            ExitEN_IB_RAU <= issue && head.exit;
            if (issue) begin
                last          <= sel_warp;
                bundle_q      <= head.f;
                HWWarp_IB_RAU <= sel_warp;
                if (head.exit) ExitWarpID_IB_RAU <= sel_warp;
            end
        end
    end

    assign {Instr_IB_OC, Src1_IB_OC, Src1_Valid_IB_OC, Src2_IB_OC, Src2_Valid_IB_OC,
            Imme_IB_OC, Imme_Valid_IB_OC, ALUop_IB_OC, RegWrite_IB_OC, MemWrite_IB_OC,
            MemRead_IB_OC, Shared_Globalbar_IB_OC, BEQ_IB_OC, BLT_IB_OC, ScbID_IB_OC,
            ActiveMask_IB_OC} = bundle_q;
endmodule

// File: tb/tb_ib_issue_unit.sv
// Directed bench for ib_issue_unit; expected issues are queued when stimulus is driven
// and compared by a monitor when Valid_IB_OC appears.
module tb_ib_issue_unit;
    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  src1;
        logic        src1_valid;
        logic [4:0]  src2;
        logic        src2_valid;
        logic [15:0] imme;
        logic        imme_valid;
        logic [3:0]  aluop;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        shared_globalbar;
        logic        beq;
        logic        blt;
        logic [1:0]  scb_id;
        logic [7:0]  active_mask;
    } bun_t;

    typedef struct packed {
        bun_t       b;
        logic [2:0] w;
        logic       ex;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic Valid_ID_IB = 1'b0, Exit_ID_IB = 1'b0;
    logic [2:0] HWWarp_ID_IB = '0;
    bun_t in_b = '0;
    logic Full_OC_IB = 1'b0, AllocStall_RAU_IB = 1'b0;
    logic BrResolve_EX_IB = 1'b0, BrTaken_EX_IB = 1'b0;
    logic [2:0] BrWarp_EX_IB = '0;

    logic [7:0]  Full_IB_ID;
    logic        Valid_IB_OC, ExitEN_IB_RAU;
    logic [2:0]  HWWarp_IB_RAU, ExitWarpID_IB_RAU;
    logic [31:0] Instr_IB_OC;
    logic [4:0]  Src1_IB_OC, Src2_IB_OC;
    logic        Src1_Valid_IB_OC, Src2_Valid_IB_OC, Imme_Valid_IB_OC;
    logic [15:0] Imme_IB_OC;
    logic [3:0]  ALUop_IB_OC;
    logic        RegWrite_IB_OC, MemWrite_IB_OC, MemRead_IB_OC, Shared_Globalbar_IB_OC;
    logic        BEQ_IB_OC, BLT_IB_OC;
    logic [1:0]  ScbID_IB_OC;
    logic [7:0]  ActiveMask_IB_OC;
    bun_t        out_b;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;

    ib_issue_unit dut (
        .clk(clk), .rst_n(rst_n),
        .Valid_ID_IB(Valid_ID_IB), .HWWarp_ID_IB(HWWarp_ID_IB),
        .Instr_ID_IB(in_b.instr), .Src1_ID_IB(in_b.src1), .Src1_Valid_ID_IB(in_b.src1_valid),
        .Src2_ID_IB(in_b.src2), .Src2_Valid_ID_IB(in_b.src2_valid), .Imme_ID_IB(in_b.imme),
        .Imme_Valid_ID_IB(in_b.imme_valid), .ALUop_ID_IB(in_b.aluop),
        .RegWrite_ID_IB(in_b.reg_write), .MemWrite_ID_IB(in_b.mem_write),
        .MemRead_ID_IB(in_b.mem_read), .Shared_Globalbar_ID_IB(in_b.shared_globalbar),
        .BEQ_ID_IB(in_b.beq), .BLT_ID_IB(in_b.blt), .ScbID_ID_IB(in_b.scb_id),
        .ActiveMask_ID_IB(in_b.active_mask), .Exit_ID_IB(Exit_ID_IB),
        .Full_IB_ID(Full_IB_ID), .Full_OC_IB(Full_OC_IB), .AllocStall_RAU_IB(AllocStall_RAU_IB),
        .BrResolve_EX_IB(BrResolve_EX_IB), .BrWarp_EX_IB(BrWarp_EX_IB),
        .BrTaken_EX_IB(BrTaken_EX_IB), .Valid_IB_OC(Valid_IB_OC),
        .Instr_IB_OC(Instr_IB_OC), .Src1_IB_OC(Src1_IB_OC), .Src1_Valid_IB_OC(Src1_Valid_IB_OC),
        .Src2_IB_OC(Src2_IB_OC), .Src2_Valid_IB_OC(Src2_Valid_IB_OC), .Imme_IB_OC(Imme_IB_OC),
        .Imme_Valid_IB_OC(Imme_Valid_IB_OC), .ALUop_IB_OC(ALUop_IB_OC),
        .RegWrite_IB_OC(RegWrite_IB_OC), .MemWrite_IB_OC(MemWrite_IB_OC),
        .MemRead_IB_OC(MemRead_IB_OC), .Shared_Globalbar_IB_OC(Shared_Globalbar_IB_OC),
        .BEQ_IB_OC(BEQ_IB_OC), .BLT_IB_OC(BLT_IB_OC), .ScbID_IB_OC(ScbID_IB_OC),
        .ActiveMask_IB_OC(ActiveMask_IB_OC), .HWWarp_IB_RAU(HWWarp_IB_RAU),
        .ExitEN_IB_RAU(ExitEN_IB_RAU), .ExitWarpID_IB_RAU(ExitWarpID_IB_RAU)
    );

    assign out_b = {Instr_IB_OC, Src1_IB_OC, Src1_Valid_IB_OC, Src2_IB_OC, Src2_Valid_IB_OC,
                    Imme_IB_OC, Imme_Valid_IB_OC, ALUop_IB_OC, RegWrite_IB_OC, MemWrite_IB_OC,
                    MemRead_IB_OC, Shared_Globalbar_IB_OC, BEQ_IB_OC, BLT_IB_OC, ScbID_IB_OC,
                    ActiveMask_IB_OC};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bun_t mk(input logic [31:0] ins, input logic beq, input logic blt);
        bun_t b;
        b.instr            = ins;
        b.src1             = ins[4:0];
        b.src1_valid       = ins[5];
        b.src2             = ins[10:6];
        b.src2_valid       = ins[11];
        b.imme             = ins[31:16];
        b.imme_valid       = ins[12];
        b.aluop            = ins[15:12];
        b.reg_write        = ins[13];
        b.mem_write        = ins[14];
        b.mem_read         = ins[15];
        b.shared_globalbar = ins[16];
        b.beq              = beq;
        b.blt              = blt;
        b.scb_id           = ins[1:0] ^ 2'b11;
        b.active_mask      = ins[23:16] ^ 8'hA5;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] w, input logic [31:0] ins, input logic beq,
                         input logic blt, input logic ex);
        Valid_ID_IB  = 1'b1;
        HWWarp_ID_IB = w;
        in_b         = mk(ins, beq, blt);
        Exit_ID_IB   = ex;
    endtask

    task automatic expect_issue(input logic [2:0] w, input logic [31:0] ins, input logic beq,
                                input logic blt, input logic ex);
        sb.push_back('{b: mk(ins, beq, blt), w: w, ex: ex});
    endtask

    task automatic idle();
        Valid_ID_IB     = 1'b0;
        Exit_ID_IB      = 1'b0;
        BrResolve_EX_IB = 1'b0;
        BrTaken_EX_IB   = 1'b0;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst_n && Valid_IB_OC) begin
            if (sb.size() == 0) begin
                check("unexpected_issue", 96'(Valid_IB_OC), 96'd0);
            end else begin
                mon_e = sb.pop_front();
                check("bundle", 96'(out_b), 96'(mon_e.b));
                check("issue_warp", 96'(HWWarp_IB_RAU), 96'(mon_e.w));
                check("exit_en", 96'(ExitEN_IB_RAU), 96'(mon_e.ex));
                if (mon_e.ex) check("exit_warp", 96'(ExitWarpID_IB_RAU), 96'(mon_e.w));
            end
        end else if (rst_n) begin
            check("exit_en_idle", 96'(ExitEN_IB_RAU), 96'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        // Reset values
        idle();
        tick();
        tick();
        check("rst_ctrl", 96'({Valid_IB_OC, ExitEN_IB_RAU, Full_IB_ID, HWWarp_IB_RAU, ExitWarpID_IB_RAU}), 96'd0);
        check("rst_bundle", 96'(out_b), 96'd0);
        rst_n = 1'b1;
        tick();

        // Single ALU instruction to warp 3: two-cycle write-to-issue latency
        drive(3'd3, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        expect_issue(3'd3, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("a_lat1", 96'(Valid_IB_OC), 96'd0);
        tick();
        check("a_lat2", 96'(Valid_IB_OC), 96'd1);
        check("a_warp", 96'(HWWarp_IB_RAU), 96'd3);
        tick();
        check("a_after", 96'(Valid_IB_OC), 96'd0);

        // Round-robin over warps 0,2,5 with two entries each (fresh pointer)
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        Full_OC_IB = 1'b1;
        drive(3'd0, 32'hA000_0001, 1'b0, 1'b0, 1'b0); tick();
        drive(3'd0, 32'hA000_0002, 1'b0, 1'b0, 1'b0); tick();
        drive(3'd2, 32'hB000_0801, 1'b0, 1'b0, 1'b0); tick();
        drive(3'd2, 32'hB000_0802, 1'b0, 1'b0, 1'b0); tick();
        drive(3'd5, 32'hC0FF_3001, 1'b0, 1'b0, 1'b0); tick();
        drive(3'd5, 32'hC0FF_3002, 1'b0, 1'b0, 1'b0); tick();
        idle();
        check("b_full_all", 96'(Full_IB_ID), 96'h25);
        check("b_no_issue", 96'(Valid_IB_OC), 96'd0);
        expect_issue(3'd0, 32'hA000_0001, 1'b0, 1'b0, 1'b0);
        expect_issue(3'd2, 32'hB000_0801, 1'b0, 1'b0, 1'b0);
        expect_issue(3'd5, 32'hC0FF_3001, 1'b0, 1'b0, 1'b0);
        expect_issue(3'd0, 32'hA000_0002, 1'b0, 1'b0, 1'b0);
        expect_issue(3'd2, 32'hB000_0802, 1'b0, 1'b0, 1'b0);
        expect_issue(3'd5, 32'hC0FF_3002, 1'b0, 1'b0, 1'b0);
        Full_OC_IB = 1'b0;
        tick(); check("b_v0", 96'(Valid_IB_OC), 96'd1); check("b_full1", 96'(Full_IB_ID), 96'h24);
        tick(); check("b_v1", 96'(Valid_IB_OC), 96'd1); check("b_full2", 96'(Full_IB_ID), 96'h20);
        tick(); check("b_v2", 96'(Valid_IB_OC), 96'd1); check("b_full3", 96'(Full_IB_ID), 96'h00);
        tick(); check("b_v3", 96'(Valid_IB_OC), 96'd1);
        tick(); check("b_v4", 96'(Valid_IB_OC), 96'd1);
        tick(); check("b_v5", 96'(Valid_IB_OC), 96'd1);
        tick(); check("b_drained", 96'(Valid_IB_OC), 96'd0);

        // Backpressure from the OC, then from the RAU, on warp 1
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) Full_OC_IB = 1'b1; else AllocStall_RAU_IB = 1'b1;
            drive(3'd1, 32'h5150_0000 + 32'(pass), 1'b0, 1'b0, 1'b0);
            expect_issue(3'd1, 32'h5150_0000 + 32'(pass), 1'b0, 1'b0, 1'b0);
            tick();
            idle();
            for (int i = 0; i < 3; i++) begin
                check("c_held", 96'(Valid_IB_OC), 96'd0);
                tick();
            end
            check("c_held_last", 96'(Valid_IB_OC), 96'd0);
            Full_OC_IB = 1'b0;
            AllocStall_RAU_IB = 1'b0;
            tick();
            check("c_resume", 96'(Valid_IB_OC), 96'd1);
            tick();
        end

        // Branch on warp 4 resolved not-taken: the following ADD issues two cycles later
        drive(3'd4, 32'hBE00_0010, 1'b1, 1'b0, 1'b0);
        expect_issue(3'd4, 32'hBE00_0010, 1'b1, 1'b0, 1'b0);
        tick();
        drive(3'd4, 32'hADD0_0011, 1'b0, 1'b0, 1'b0);
        expect_issue(3'd4, 32'hADD0_0011, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("d_branch", 96'(Valid_IB_OC), 96'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("d_blocked", 96'(Valid_IB_OC), 96'd0);
        end
        BrResolve_EX_IB = 1'b1; BrWarp_EX_IB = 3'd4; BrTaken_EX_IB = 1'b0;
        tick();
        idle();
        check("d_res_lat1", 96'(Valid_IB_OC), 96'd0);
        tick();
        check("d_res_lat2", 96'(Valid_IB_OC), 96'd1);
        tick();

        // Branch on warp 4 resolved taken: the queued instruction is flushed
        drive(3'd4, 32'hB170_0020, 1'b0, 1'b1, 1'b0);
        expect_issue(3'd4, 32'hB170_0020, 1'b0, 1'b1, 1'b0);
        tick();
        drive(3'd4, 32'hDEAD_0021, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("d2_branch", 96'(Valid_IB_OC), 96'd1);
        tick();
        BrResolve_EX_IB = 1'b1; BrWarp_EX_IB = 3'd4; BrTaken_EX_IB = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            check("d2_flushed", 96'(Valid_IB_OC), 96'd0);
            tick();
        end
        drive(3'd4, 32'h5AB0_0022, 1'b0, 1'b0, 1'b0);
        expect_issue(3'd4, 32'h5AB0_0022, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        check("d2_unblocked", 96'(Valid_IB_OC), 96'd1);
        tick();

        // Exit on warp 6 drops the queued entry and a same-cycle write
        Full_OC_IB = 1'b1;
        drive(3'd6, 32'hE817_0030, 1'b0, 1'b0, 1'b1);
        expect_issue(3'd6, 32'hE817_0030, 1'b0, 1'b0, 1'b1);
        tick();
        drive(3'd6, 32'hDEAD_0031, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("e_full6", 96'(Full_IB_ID), 96'h40);
        Full_OC_IB = 1'b0;
        drive(3'd6, 32'hDEAD_0032, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("e_valid", 96'(Valid_IB_OC), 96'd1);
        check("e_exit_en", 96'(ExitEN_IB_RAU), 96'd1);
        check("e_exit_warp", 96'(ExitWarpID_IB_RAU), 96'd6);
        check("e_empty", 96'(Full_IB_ID), 96'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("e_dropped", 96'(Valid_IB_OC), 96'd0);
        end

        // Mid-stream reset with four warps loaded and warp 3 branch-pending
        drive(3'd3, 32'hBE00_0040, 1'b1, 1'b0, 1'b0);
        expect_issue(3'd3, 32'hBE00_0040, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        check("f_branch", 96'(Valid_IB_OC), 96'd1);
        Full_OC_IB = 1'b1;
        drive(3'd0, 32'h0F00_0041, 1'b0, 1'b0, 1'b0); tick();
        drive(3'd1, 32'h0F00_0042, 1'b0, 1'b0, 1'b0); tick();
        drive(3'd2, 32'h0F00_0043, 1'b0, 1'b0, 1'b0); tick();
        drive(3'd3, 32'h0F00_0044, 1'b0, 1'b0, 1'b0); tick();
        idle();
        rst_n = 1'b0;
        Full_OC_IB = 1'b0;
        tick();
        check("f_rst_ctrl", 96'({Valid_IB_OC, ExitEN_IB_RAU, Full_IB_ID, HWWarp_IB_RAU, ExitWarpID_IB_RAU}), 96'd0);
        check("f_rst_bundle", 96'(out_b), 96'd0);
        rst_n = 1'b1;
        tick();
        drive(3'd7, 32'h7777_0050, 1'b0, 1'b0, 1'b0);
        expect_issue(3'd7, 32'h7777_0050, 1'b0, 1'b0, 1'b0);
        tick();
        drive(3'd3, 32'h3333_0051, 1'b0, 1'b0, 1'b0);
        expect_issue(3'd3, 32'h3333_0051, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("f_w7_valid", 96'(Valid_IB_OC), 96'd1);
        check("f_w7_warp", 96'(HWWarp_IB_RAU), 96'd7);
        tick();
        check("f_w3_valid", 96'(Valid_IB_OC), 96'd1);
        check("f_w3_warp", 96'(HWWarp_IB_RAU), 96'd3);

        t = 0;
        while (sb.size() != 0 && t < 20) begin
            tick();
            t++;
        end
        tick();
        check("sb_drain", 96'(sb.size()), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
